fetch_stage: RTL
================

Name: fetch_stage

Overview:
- IF stage of the 64-bit RV pipeline; the producer end of the IF/ID interface that decode_stage consumes.
- Owns PCF and issues requests to instruction memory with a req/ready handshake.
- Drives the IF/ID register outputs InstrD, PCD, PCPlus4D and ValidD.
- Accepts redirects (PCSF, PCTargetD) from decode and stall/flush controls from the hazard unit.

Parameters:
- XLEN, 64, PC/address width.
- RESET_PC, 64'h0, PC loaded on reset.
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- StallF  input  1  freeze PC; no new request issued.
- StallD  input  1  freeze IF/ID register; hazard-unit contract: StallD=1 implies StallF=1.
- FlushD  input  1  load bubble into IF/ID.
- PCSF  input  1  redirect taken (branch/jump resolved in decode).
- PCTargetD  input  XLEN  redirect target.
- IMemReq  output  1  fetch request valid.
- IMemAddr  output  XLEN  fetch address; equals PCF.
- IMemReady  input  1  memory returns IMemRdata this cycle; may be combinational with IMemReq.
- IMemRdata  input  32  instruction word.
- InstrD  output  32  IF/ID instruction.
- PCD  output  XLEN  IF/ID PC.
- PCPlus4D  output  XLEN  IF/ID PC+4.
- ValidD  output  1  IF/ID holds a real instruction.

Behaviour:
- Accept = IMemReq & IMemReady. Once IMemReq is high, IMemReq and IMemAddr stay stable until the accept.
- Reset (rst=1 at an edge, any state): PCF=RESET_PC, state=REQ, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, hold buffer invalid.
- Reset mid-operation discards any outstanding request or buffered word. IMemReq is high the cycle after reset deasserts (state REQ, StallF=0).
- States:
  - IDLE: IMemReq=0. Entered when StallF=1 and nothing is outstanding.
  - REQ: IMemReq=1.
  - HOLD: IMemReq=0; one-entry buffer holds {instr, pc}.
  - REDIR: IMemReq=1; the pending word will be discarded.
- REQ, accept, StallD=0: IF/ID <= {IMemRdata, PCF, PCF+4}, ValidD=1, PCF <= PCF+4. Next state is REQ, or IDLE if StallF=1.
- REQ, accept, StallD=1: buffer <= {IMemRdata, PCF}, PCF <= PCF+4, go to HOLD. IF/ID is unchanged.
- REQ, no accept: stay in REQ. If StallD=0, IF/ID <= bubble (NOP_INSTR, ValidD=0; PCD and PCPlus4D unchanged).
- IDLE: when StallF=0, go to REQ. IF/ID gets a bubble if StallD=0.
- HOLD: when StallD=0, IF/ID <= buffer with ValidD=1 and PCPlus4D=pc+4. Next state is REQ, or IDLE if StallF=1.
- Fetch latency: a zero-wait accept in cycle n makes InstrD valid after edge n.
- Redirect (PCSF=1) priority order is rst > PCSF > FlushD > StallD/StallF.
  - PCF <= {PCTargetD[XLEN-1:2], 2'b00}.
  - IF/ID <= bubble even if StallD=1.
  - Hold buffer is dropped.
  - From REQ with no accept: go to REDIR. With an accept in the same cycle: the word is discarded, go to REQ.
  - From IDLE or HOLD: go to REQ (IDLE if StallF=1).
- REDIR: on accept, discard IMemRdata and go to REQ. IMemAddr must stay at the old address until that accept, so PCF is not updated until then: the target is held in a pending register and loaded into PCF on the discard accept.
- A second PCSF while in REDIR overwrites the pending target.
- FlushD without PCSF: bubble into IF/ID. Fetch state, PCF and the hold buffer are unaffected.
- Arithmetic: PC+4 wraps modulo 2^XLEN.

Decomposition:
- Shared pipeline package holds:
  - fetch state enum (IDLE, REQ, HOLD, REDIR);
  - NOP_INSTR constant;
  - XLEN.
- One sub-module, if_id_reg: IF/ID register with load/bubble/hold controls and reset values as above.
- PC, FSM, pending-target register and hold buffer stay in fetch_stage.

Test Plan:
- Reset, zero-wait memory (IMemReady=1, mem[a]=a|0x13), no stalls -> IMemAddr 0,4,8,... on consecutive cycles; InstrD/PCD = (0x13,0),(0x17,4),...; PCPlus4D=PCD+4; ValidD=1 from the 2nd cycle.
- IMemReady low for 2 cycles at addr 0x8 -> IMemAddr stays at 0x8 for 3 cycles; 2 bubbles (ValidD=0, InstrD=0x13); then PCD=0x8.
- PCSF=1, PCTargetD=0x42 in the cycle addr 0x10 is accepted -> next IMemAddr=0x40; InstrD=NOP with ValidD=0; then PCD=0x40 and no instruction at 0x10 delivered.
- PCSF=1, target 0x80 while addr 0x10 is pending (ready low) -> IMemAddr stays 0x10 until ready; that word is discarded; next IMemAddr=0x80.
- StallF=StallD=1 for 3 cycles starting at the accept of 0xC -> IMemReq=0, IF/ID unchanged; on release PCD=0xC, ValidD=1; next IMemAddr=0x10.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC: after first accept IMemAddr=0. Asserting rst while in HOLD -> ValidD=0, InstrD=NOP, IMemAddr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// fetch_stage_pkg : shared pipeline types and constants for the fetch stage
// Revision 1.0
// ============================================================================
package fetch_stage_pkg;

    localparam int          c_XLEN      = 64;
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_REDIR = 2'd3
    } fetchState_e;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// if_id_reg : IF/ID pipeline register with load / bubble / hold controls
// Revision 1.0
// ============================================================================
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int          XLEN      = c_XLEN,
    parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            bubble,
    input  logic [31:0]     instrIn,
    input  logic [XLEN-1:0] pcIn,
    input  logic [XLEN-1:0] pcPlus4In,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    // A bubble leaves the PC fields alone so decode still sees the last PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (bubble) begin
            InstrD   <= NOP_INSTR;
            ValidD   <= 1'b0;
        end else if (load) begin
            InstrD   <= instrIn;
            PCD      <= pcIn;
            PCPlus4D <= pcPlus4In;
            ValidD   <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : IF stage - PC, instruction-memory handshake, IF/ID producer
// Revision 1.0
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              XLEN      = c_XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = c_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSF,
    input  logic [XLEN-1:0] PCTargetD,
    output logic            IMemReq,
    output logic [XLEN-1:0] IMemAddr,
    input  logic            IMemReady,
    input  logic [31:0]     IMemRdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    localparam logic [XLEN-1:0] c_FOUR = XLEN'(4);

    fetchState_e     r_state, w_stateNext;
    logic [XLEN-1:0] r_pcF, w_pcNext;
    logic [XLEN-1:0] r_pendPc, w_pendNext;
    logic [31:0]     r_bufInstr, w_bufInstrNext;
    logic [XLEN-1:0] r_bufPc, w_bufPcNext;

    logic            w_accept;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pcPlus4;
    logic            w_ifLoad, w_ifBubble;
    logic [31:0]     w_ifInstr;
    logic [XLEN-1:0] w_ifPc, w_ifPcPlus4;

    assign IMemReq   = (r_state == S_REQ) || (r_state == S_REDIR);
    assign IMemAddr  = r_pcF;
    assign w_accept  = IMemReq & IMemReady;
    assign w_target  = {PCTargetD[XLEN-1:2], 2'b00};
    assign w_pcPlus4 = r_pcF + c_FOUR;

    always_comb begin
        w_stateNext    = r_state;
        w_pcNext       = r_pcF;
        w_pendNext     = r_pendPc;
        w_bufInstrNext = r_bufInstr;
        w_bufPcNext    = r_bufPc;
        w_ifLoad       = 1'b0;
        w_ifBubble     = 1'b0;
        w_ifInstr      = IMemRdata;
        w_ifPc         = r_pcF;
        w_ifPcPlus4    = w_pcPlus4;

        if (PCSF) begin
            // IMemAddr must not move while a request is open, so an in-flight
            // redirect parks its target until the stale word is accepted.
            w_ifBubble = 1'b1;
            case (r_state)
                S_REQ, S_REDIR: begin
                    if (w_accept) begin
                        w_pcNext    = w_target;
                        w_stateNext = S_REQ;
                    end else begin
                        w_pendNext  = w_target;
                        w_stateNext = S_REDIR;
                    end
                end
                default: begin
                    w_pcNext    = w_target;
                    w_stateNext = StallF ? S_IDLE : S_REQ;
                end
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_ifBubble = !StallD;
                    if (!StallF) w_stateNext = S_REQ;
                end
                S_REQ: begin
                    if (w_accept) begin
                        w_pcNext = w_pcPlus4;
                        if (StallD) begin
                            w_bufInstrNext = IMemRdata;
                            w_bufPcNext    = r_pcF;
                            w_stateNext    = S_HOLD;
                        end else begin
                            w_ifLoad    = 1'b1;
                            w_stateNext = StallF ? S_IDLE : S_REQ;
                        end
                    end else begin
                        w_ifBubble = !StallD;
                    end
                end
                S_HOLD: begin
                    if (!StallD) begin
                        w_ifLoad    = 1'b1;
                        w_ifInstr   = r_bufInstr;
                        w_ifPc      = r_bufPc;
                        w_ifPcPlus4 = r_bufPc + c_FOUR;
                        w_stateNext = StallF ? S_IDLE : S_REQ;
                    end
                end
                default: begin
                    w_ifBubble = !StallD;
                    if (w_accept) begin
                        w_pcNext    = r_pendPc;
                        w_stateNext = S_REQ;
                    end
                end
            endcase

            // Flush only kills what enters IF/ID; fetch keeps going.
            if (FlushD) begin
                w_ifLoad   = 1'b0;
                w_ifBubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_pcF      <= RESET_PC;
            r_pendPc   <= '0;
            r_bufInstr <= NOP_INSTR;
            r_bufPc    <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_pcF      <= w_pcNext;
            r_pendPc   <= w_pendNext;
            r_bufInstr <= w_bufInstrNext;
            r_bufPc    <= w_bufPcNext;
        end
    end

    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifId (
        .clk       (clk),
        .rst       (rst),
        .load      (w_ifLoad),
        .bubble    (w_ifBubble),
        .instrIn   (w_ifInstr),
        .pcIn      (w_ifPc),
        .pcPlus4In (w_ifPcPlus4),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

endmodule
`default_nettype wire
